// File: rtl/snn_pkg.sv
// Shared encodings and saturating arithmetic helpers for the spiking layer.
package snn_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ACCUM = 3'd1;
   localparam logic [2:0] S_FIRE  = 3'd2;
   localparam logic [2:0] S_LEARN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [1:0] REW_POS  = 2'b01;
   localparam logic [1:0] REW_NEG  = 2'b11;
   localparam logic [1:0] REW_ZERO = 2'b00;

   function automatic int sat_add_u(input int a, input int b, input int max_v);
      return (a + b > max_v) ? max_v : a + b;
   endfunction

   function automatic int sat_step(input int w, input int step, input int min_v, input int max_v);
      int r;
      r = w + step;
      if (r > max_v) r = max_v;
      else if (r < min_v) r = min_v;
      return r;
   endfunction

   // Hebbian step: only active presynaptic inputs move; 2'b10 decodes as zero reward.
   function automatic int rew_delta(input logic [1:0] rew, input logic pre, input logic post);
      if (!pre) return 0;
      if (rew == REW_POS) return post ? 1 : -1;
      if (rew == REW_NEG) return post ? -1 : 0;
      return 0;
   endfunction

endpackage

// File: rtl/snn_shift_syn.sv
// One synapse: signed shift of an input value, saturating-added into an accumulator.
module snn_shift_syn
   import snn_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int WSH_W  = 5,
   parameter int ACC_W  = 8
) (
   input  logic [DATA_W-1:0] x_i,
   input  logic [WSH_W-1:0]  w_i,
   input  logic [ACC_W-1:0]  acc_i,
   output logic [ACC_W-1:0]  acc_o
);

   // Wide enough that the largest left shift loses no bits, so overflow is just the upper slice.
   localparam int WIDE_W = ACC_W + (1 << (WSH_W - 1));

   logic [WIDE_W-1:0] wide;
   logic [WSH_W-1:0]  rsh;
   logic [ACC_W-1:0]  term;
   logic              ovf;

   assign wide = WIDE_W'(x_i) << w_i[WSH_W-2:0];
   assign rsh  = -w_i;

   always_comb begin
      term = '0;
      ovf  = 1'b0;
      if (w_i[WSH_W-1]) begin
         term = ACC_W'(x_i) >> rsh;
      end else begin
         term = wide[ACC_W-1:0];
         ovf  = |wide[WIDE_W-1:ACC_W];
      end
   end

   assign acc_o = ovf ? '1 : ACC_W'(sat_add_u(int'(acc_i), int'(term), (1 << ACC_W) - 1));

endmodule

// File: rtl/snn_layer_core.sv
// Leaky integrate-and-fire layer with shift weights and reward-modulated Hebbian learning.
module snn_layer_core
   import snn_pkg::*;
#(
   parameter int N_IN    = 4,
   parameter int N_OUT   = 4,
   parameter int DATA_W  = 4,
   parameter int WSH_W   = 5,
   parameter int ACC_W   = 8,
   parameter int THRESH  = 1,
   parameter int LEAK_SH = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_IN*DATA_W-1:0]        in_data,
   input  logic [1:0]                    in_reward,
   input  logic                          learn_en,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_OUT-1:0]              spike,
   output logic [N_OUT*ACC_W-1:0]        v_out,
   input  logic [$clog2(N_IN*N_OUT)-1:0] w_rd_addr,
   output logic [WSH_W-1:0]              w_rd_data
);

   localparam int N_SYN   = N_IN * N_OUT;
   localparam int AW      = $clog2(N_SYN);
   localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int ACC_MAX = (1 << ACC_W) - 1;
   localparam int W_MAX   = (1 << (WSH_W - 1)) - 1;
   localparam int W_MIN   = -(1 << (WSH_W - 1));

   logic [2:0]                    state_q, state_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [N_IN-1:0][DATA_W-1:0]   x_q, x_d;
   logic [1:0]                    reward_q, reward_d;
   logic                          learn_q, learn_d;
   logic [N_OUT-1:0][ACC_W-1:0]   acc_q, acc_d, acc_nxt;
   logic [N_OUT-1:0][ACC_W-1:0]   v_q, v_d, v_fire;
   logic [N_OUT-1:0]              spike_q, spike_d;
   logic [N_SYN-1:0][WSH_W-1:0]   w_q, w_d, w_lrn;
   logic [DATA_W-1:0]             x_sel;
   logic [N_OUT-1:0][WSH_W-1:0]   w_sel;

   assign x_sel = x_q[idx_q];

   for (genvar j = 0; j < N_OUT; j++) begin : g_neu
      assign w_sel[j] = w_q[AW'(int'(idx_q) * N_OUT + j)];

      snn_shift_syn #(
         .DATA_W (DATA_W),
         .WSH_W  (WSH_W),
         .ACC_W  (ACC_W)
      ) u_syn (
         .x_i   (x_sel),
         .w_i   (w_sel[j]),
         .acc_i (acc_q[j]),
         .acc_o (acc_nxt[j])
      );

      // Leak is taken from the stored potential, then the sample's drive is added.
      assign v_fire[j] = ACC_W'(sat_add_u(int'(v_q[j] - (v_q[j] >> LEAK_SH)),
                                          int'(acc_q[j]), ACC_MAX));
   end

   for (genvar i = 0; i < N_IN; i++) begin : g_lrn_i
      for (genvar j = 0; j < N_OUT; j++) begin : g_lrn_j
         assign w_lrn[i*N_OUT+j] = WSH_W'(sat_step(int'($signed(w_q[i*N_OUT+j])),
                                                   rew_delta(reward_q, |x_q[i], spike_q[j]),
                                                   W_MIN, W_MAX));
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      x_d      = x_q;
      reward_d = reward_q;
      learn_d  = learn_q;
      acc_d    = acc_q;
      v_d      = v_q;
      spike_d  = spike_q;
      w_d      = w_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d      = in_data;
               reward_d = in_reward;
               learn_d  = learn_en;
               idx_d    = '0;
               acc_d    = '0;
               state_d  = S_ACCUM;
            end
         end
         S_ACCUM: begin
            acc_d = acc_nxt;
            idx_d = idx_q + 1'b1;
            if (int'(idx_q) == N_IN - 1) begin
               idx_d   = '0;
               state_d = S_FIRE;
            end
         end
         S_FIRE: begin
            for (int j = 0; j < N_OUT; j++) begin
               spike_d[j] = int'(v_fire[j]) > THRESH;
               v_d[j]     = (int'(v_fire[j]) > THRESH) ? '0 : v_fire[j];
            end
            state_d = S_LEARN;
         end
         S_LEARN: begin
            if (learn_q) w_d = w_lrn;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         x_q      <= '0;
         reward_q <= REW_ZERO;
         learn_q  <= 1'b0;
         acc_q    <= '0;
         v_q      <= '0;
         spike_q  <= '0;
         w_q      <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         x_q      <= x_d;
         reward_q <= reward_d;
         learn_q  <= learn_d;
         acc_q    <= acc_d;
         v_q      <= v_d;
         spike_q  <= spike_d;
         w_q      <= w_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign spike     = spike_q;
   assign v_out     = v_q;
   assign w_rd_data = (int'(w_rd_addr) < N_SYN) ? w_q[w_rd_addr] : '0;

endmodule

// File: tb/tb_snn_layer_core.sv
// Directed scoreboard bench for snn_layer_core (2 inputs x 2 neurons).
module tb_snn_layer_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic [1:0]  in_reward = '0;
   logic        learn_en = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  spike;
   logic [15:0] v_out;
   logic [1:0]  w_rd_addr = '0;
   logic [4:0]  w_rd_data;

   typedef struct packed {
      logic [1:0]  spk;
      logic [15:0] v;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   snn_layer_core #(
      .N_IN(2), .N_OUT(2), .DATA_W(4), .WSH_W(5), .ACC_W(8), .THRESH(1), .LEAK_SH(1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_reward (in_reward),
      .learn_en  (learn_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .spike     (spike),
      .v_out     (v_out),
      .w_rd_addr (w_rd_addr),
      .w_rd_data (w_rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, $signed(act), $signed(want));
      end
   endtask

   task automatic chk_w(input int k, input int want);
      w_rd_addr = 2'(k);
      #1;
      chk($sformatf("w%0d", k), 32'($signed(w_rd_data)), want);
   endtask

   task automatic chk_wall(input int w00, input int w01, input int w10, input int w11);
      chk_w(0, w00);
      chk_w(1, w01);
      chk_w(2, w10);
      chk_w(3, w11);
   endtask

   // Offer a sample, push its hand-computed result on accept, check the out_valid latency.
   task automatic issue(input int x0, input int x1, input logic [1:0] rew, input logic lrn,
                        input int espk, input int ev0, input int ev1);
      int n;
      in_data   = {4'(x1), 4'(x0)};
      in_reward = rew;
      learn_en  = lrn;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk);
      sb_q.push_back({2'(espk), 8'(ev1), 8'(ev0)});
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", 32'(n), 32'd4);
   endtask

   task automatic drain();
      int n = 0;
      while (out_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("drain", 32'(out_valid), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out spike=%b v_out=%h expected none", spike, v_out);
         end else begin
            mon_e = sb_q.pop_front();
            chk("spike", 32'(spike), 32'(mon_e.spk));
            chk("v_out", 32'(v_out), 32'(mon_e.v));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_spike", 32'(spike), 32'd0);
      chk("rst_v_out", 32'(v_out), 32'd0);
      chk_wall(0, 0, 0, 0);

      // Accept a sample, then reset in the middle of ACCUM: it must vanish.
      in_data = {4'd2, 4'd3}; in_reward = 2'b01; learn_en = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      chk("abort_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk_wall(0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         chk("abort_no_out", 32'(out_valid), 32'd0);
      end

      // acc = 3+2 = 5 > 1 on both neurons, reward 0 leaves weights.
      issue(3, 2, 2'b00, 1'b1, 3, 0, 0); drain(); chk_wall(0, 0, 0, 0);
      issue(3, 0, 2'b01, 1'b1, 3, 0, 0); drain(); chk_wall(1, 1, 0, 0);
      issue(3, 0, 2'b01, 1'b1, 3, 0, 0); drain(); chk_wall(2, 2, 0, 0);
      // 3 << w saturates at 255 once w >= 7; weight saturates at 15.
      for (int k = 0; k < 20; k++) begin
         issue(3, 0, 2'b01, 1'b1, 3, 0, 0); drain();
      end
      chk_wall(15, 15, 0, 0);
      // 15 shifted by w = 15..-1 always exceeds 1, so 17 punished spikes take w to -2.
      for (int k = 0; k < 17; k++) begin
         issue(15, 0, 2'b11, 1'b1, 3, 0, 0); drain();
      end
      chk_wall(-2, -2, 0, 0);

      // 4 >> 2 = 1, no spike, v = 1 held; out_ready low while a new sample waits.
      out_ready = 1'b0;
      issue(4, 0, 2'b01, 1'b0, 0, 1, 1);
      in_data = {4'd0, 4'd8}; in_reward = 2'b01; learn_en = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_spike", 32'(spike), 32'(sb_q[0].spk));
         chk("hold_v", 32'(v_out), 32'(sb_q[0].v));
      end
      @(posedge clk); #1 out_ready = 1'b1;
      // leak(1) = 1, plus 8 >> 2 = 2 -> 3 fires; learning frozen.
      issue(8, 0, 2'b01, 1'b0, 3, 0, 0); drain(); chk_wall(-2, -2, 0, 0);

      // 2'b10 is zero reward even with pre and post active.
      issue(15, 0, 2'b10, 1'b1, 3, 0, 0); drain(); chk_wall(-2, -2, 0, 0);
      // Negative reward without a spike leaves weights.
      issue(3, 0, 2'b11, 1'b1, 0, 0, 0); drain(); chk_wall(-2, -2, 0, 0);
      // Only the active input row learns.
      issue(0, 5, 2'b01, 1'b1, 3, 0, 0); drain(); chk_wall(-2, -2, 1, 1);

      repeat (5) @(posedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
